md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, cycles busy after a multiply start.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, cycles busy after a divide start.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  launch the operation in op (E-stage instruction valid).
REQ-006 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port A  input  32  rs operand (forwarded value).
REQ-008 SHALL have port B  input  32  rt operand (forwarded value).
REQ-009 SHALL have port req  input  1  exception/interrupt flush; suppresses the same-cycle start.
REQ-010 SHALL have port busy  output  1  registered; high while an operation is in progress.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.

Function
REQ-013 SHALL accept a start only when start=1, req=0 and busy=0; all other starts are ignored.
REQ-014 SHALL compute MULT as a signed 32x32->64 product, with HI=upper and LO=lower.
REQ-015 SHALL compute MULTU as an unsigned 32x32->64 product, with HI=upper and LO=lower.
REQ-016 SHALL compute DIV as signed division: LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign.
REQ-017 SHALL compute DIVU as unsigned division: LO=quotient, HI=remainder.
REQ-018 SHALL, for DIV with A=0x80000000 and B=0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-019 SHALL, for DIV or DIVU with B=0, leave HI and LO unchanged, while busy still runs the full DIV_CYCLES.
REQ-020 SHALL latch the result into internal pending registers at the accepted start; HI and LO SHALL keep their old values until completion.
REQ-021 SHALL use a two-state FSM: IDLE and BUSY.
REQ-022 SHALL, on an accepted MULT or MULTU, go IDLE->BUSY with a down-counter loaded to MULT_CYCLES.
REQ-023 SHALL, on an accepted DIV or DIVU, go IDLE->BUSY with the down-counter loaded to DIV_CYCLES.
REQ-024 SHALL, in BUSY, decrement the counter every cycle; on the cycle it reaches 1, return to IDLE and commit the pending values to HI and LO.
REQ-025 SHALL keep busy high for exactly N consecutive cycles starting the cycle after the accepted start (N = MULT_CYCLES or DIV_CYCLES).
REQ-026 SHALL make committed HI and LO visible in the same cycle that busy falls.
REQ-027 SHALL, on an accepted MTHI, write A to HI at the next edge, with busy staying 0 and LO unchanged.
REQ-028 SHALL, on an accepted MTLO, write A to LO at the next edge, with busy staying 0 and HI unchanged.
REQ-029 SHALL NOT let req abort an operation already in BUSY; it runs to completion and commits.
REQ-030 SHALL treat undefined op values as no-ops.
REQ-031 SHALL require the stall unit to hold off dependent MF/MT/MD instructions using (start|busy); the block itself SHALL NOT queue operations.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set HI=0, LO=0, busy=0, state=IDLE, counter=0 and pending=0.
REQ-033 SHALL let reset asserted mid-operation abandon the operation without committing.
REQ-034 SHALL give reset priority over start and req in the same cycle.

Structure
REQ-035 SHALL place op encodings, the default MULT_CYCLES and DIV_CYCLES values and the FSM state encoding in shared package md_defs.
REQ-036 SHALL use one combinational sub-module, md_calc (inputs op, A, B; outputs 64-bit result and a write-enable that is 0 for a zero divisor), instantiated once.

Verification
REQ-037 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy high for cycles 1-5, then HI=0xFFFFFFFF and LO=0xFFFFFFFA with busy falling at cycle 5.
REQ-038 SHALL cover: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE and LO=0x00000001.
REQ-039 SHALL cover: DIV A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1); DIVU A=7, B=0 with HI=LO=0x1234 beforehand -> busy for 10 cycles, HI and LO still 0x1234.
REQ-040 SHALL cover: start DIV, then a second start=1 MULT at cycle 3 -> second start ignored and the first result committed at cycle 10.
REQ-041 SHALL cover: start=1 with req=1 -> busy stays 0 and HI/LO unchanged; MTLO A=0xABCD0000 -> LO updated next cycle, busy=0.
REQ-042 SHALL cover: reset asserted at cycle 4 of a MULT -> next cycle busy=0 and HI=LO=0, with no later commit.

Source files
------------

// File: rtl/md_defs.sv
// md_defs: shared op encodings, default latencies and FSM state encoding for the multiply/divide unit.
package md_defs;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath.
//   op       in  3   operation code (md_defs::op_e)
//   A, B     in  32  rs / rt operands
//   o_result out 64  {HI, LO} value for MULT/MULTU/DIV/DIVU, 0 otherwise
//   o_we     out 1   result is to be committed (0 for a zero divisor or non-MD op)
module md_calc
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] o_result,
    output logic        o_we
);

    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_div_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_s;
    logic [31:0] w_uq, w_ur;
    logic [31:0] w_mq, w_mr;
    logic [31:0] w_sq, w_sr;
    logic        w_mul;
    logic        w_div;

    // Lower 64 bits of the sign-extended product equal the signed product.
    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_umul = {32'd0, A} * {32'd0, B};

    // Divisors forced to 1 when zero so the datapath never divides by zero;
    // the result is discarded through o_we in that case.
    assign w_div_u = (B == 32'd0) ? 32'd1 : B;
    assign w_uq    = A / w_div_u;
    assign w_ur    = A % w_div_u;

    // Signed division on magnitudes: 0x80000000 as an unsigned magnitude is
    // exact, so 0x80000000 / -1 naturally yields quotient 0x80000000, rem 0.
    assign w_abs_a = A[31] ? -A : A;
    assign w_abs_b = B[31] ? -B : B;
    assign w_div_s = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_mq    = w_abs_a / w_div_s;
    assign w_mr    = w_abs_a % w_div_s;
    assign w_sq    = (A[31] ^ B[31]) ? -w_mq : w_mq;
    assign w_sr    = A[31] ? -w_mr : w_mr;

    assign w_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_div = (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        o_result = (op == OP_MULT)  ? w_smul :
                   (op == OP_MULTU) ? w_umul :
                   (op == OP_DIV)   ? {w_sr, w_sq} :
                   (op == OP_DIVU)  ? {w_ur, w_uq} : 64'd0;
        o_we     = w_mul || (w_div && (B != 32'd0));
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle HI/LO multiply/divide unit with fixed latency.
//   clk, reset in  1   clock, synchronous active-high reset
//   start      in  1   launch op (ignored while busy or when req=1)
//   op         in  3   MULT, MULTU, DIV, DIVU, MTHI, MTLO (others no-op)
//   A, B       in  32  rs / rt operands
//   req        in  1   exception/interrupt flush of the same-cycle start
//   busy       out 1   registered, high while an operation is in flight
//   HI, LO     out 32  architectural HI / LO registers
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    state_e      r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_pend;
    logic        r_pend_we;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_result;
    logic        w_we;
    logic        w_go;
    logic        w_mul;
    logic        w_div;

    md_calc u_calc (
        .op       (op),
        .A        (A),
        .B        (B),
        .o_result (w_result),
        .o_we     (w_we)
    );

    assign w_go  = start & ~req & ~r_busy;
    assign w_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_div = (op == OP_DIV) || (op == OP_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_we <= 1'b0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        if (w_mul || w_div) begin
                            r_state   <= S_BUSY;
                            r_busy    <= 1'b1;
                            r_cnt     <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            r_pend    <= w_result;
                            r_pend_we <= w_we;
                        end else if (op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_pend_we) begin
                            r_hi <= r_pend[63:32];
                            r_lo <= r_pend[31:0];
                        end
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;
    import md_defs::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, req;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .req   (req),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic eb, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, " HI"}, HI, eh);
        chk({tag, " LO"}, LO, el);
    endtask

    // Reference: latency and resulting HI/LO from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = m_hi;
        el = m_lo;
        n = 0;
        case (o)
            3'd0: begin t = sa * sb; eh = t[63:32]; el = t[31:0]; n = MC; end
            3'd1: begin t = ua * ub; eh = t[63:32]; el = t[31:0]; n = MC; end
            3'd2: begin
                n = DC;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    t = sq; el = t[31:0];
                    t = sr; eh = t[31:0];
                end
            end
            3'd3: begin
                n = DC;
                if (b != 0) begin
                    t = ua / ub; el = t[31:0];
                    t = ua % ub; eh = t[31:0];
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endtask

    // Launch one op, scramble operands while busy, check every busy cycle and the commit.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold_req);
        int n;
        logic [31:0] eh, el;
        model(o, a, b, n, eh, el);
        op = o; A = a; B = b; start = 1'b1; req = 1'b0;
        tick;
        start = 1'b0;
        req = hold_req;
        for (int i = 1; i <= n; i++) begin
            A = $urandom; B = $urandom;
            chk_state($sformatf("op%0d c%0d", o, i), 1'b1, m_hi, m_lo);
            tick;
        end
        req = 1'b0;
        chk_state($sformatf("op%0d done", o), 1'b0, eh, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        int n;
        logic [31:0] eh, el, ra, rb;
        logic [2:0] ro;
        reset = 1'b1; start = 1'b0; req = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        tick;
        tick;
        reset = 1'b0;
        chk_state("reset", 1'b0, 32'd0, 32'd0);

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult hi", HI, 32'hFFFFFFFF);
        chk("mult lo", LO, 32'hFFFFFFFA);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu hi", HI, 32'hFFFFFFFE);
        chk("multu lo", LO, 32'h00000001);

        run_op(OP_DIV, -32'sd7, 32'd2, 1'b0);
        chk("div hi", HI, 32'hFFFFFFFF);
        chk("div lo", LO, 32'hFFFFFFFD);

        run_op(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        run_op(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        run_op(OP_DIVU, 32'd7, 32'd0, 1'b0);
        chk("div0 hi", HI, 32'h1234);
        chk("div0 lo", LO, 32'h1234);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf hi", HI, 32'h0);
        chk("ovf lo", LO, 32'h80000000);

        // Second start while busy must be ignored.
        model(OP_DIV, 32'd100, 32'd7, n, eh, el);
        op = OP_DIV; A = 32'd100; B = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        op = OP_MULT; A = 32'd9; B = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 4; i <= DC; i++) begin
            chk_state($sformatf("ign c%0d", i), 1'b1, m_hi, m_lo);
            tick;
        end
        chk_state("ign done", 1'b0, eh, el);
        m_hi = eh; m_lo = el;

        // Start suppressed by req.
        op = OP_MULT; A = 32'd5; B = 32'd6; start = 1'b1; req = 1'b1;
        tick;
        op = OP_MTHI;
        tick;
        start = 1'b0; req = 1'b0;
        chk_state("req flush", 1'b0, m_hi, m_lo);
        tick;
        chk_state("req flush2", 1'b0, m_hi, m_lo);

        run_op(OP_MTLO, 32'hABCD0000, 32'd0, 1'b0);
        chk("mtlo lo", LO, 32'hABCD0000);

        // req during BUSY does not abort.
        run_op(OP_MULTU, 32'h00012345, 32'h00067890, 1'b1);
        run_op(OP_DIV, 32'hFFFF0000, 32'd3, 1'b1);

        // Reset mid-operation abandons it.
        op = OP_MULT; A = 32'd1000; B = 32'd1000; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk_state("rst mid", 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk_state($sformatf("rst after%0d", i), 1'b0, 32'd0, 32'd0);
        end

        // Reset beats start.
        op = OP_MTHI; A = 32'h55; start = 1'b1; reset = 1'b1;
        tick;
        start = 1'b0; reset = 1'b0;
        chk_state("rst prio", 1'b0, 32'd0, 32'd0);

        for (int k = 0; k < 60; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
